// File: rtl/shifter_arbiter.sv
// Round-robin shared shifter: NREQ valid/ready requesters compete for one registered
// operand stage feeding a combinational shifter, with a single tagged response channel.

module shifter #(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0]         a,
  input  logic [$clog2(WIDTH)-1:0] b,
  input  logic                     rot,
  input  logic                     left,
  input  logic                     sign,
  output logic [WIDTH-1:0]         y
);

  logic [2*WIDTH-1:0] dbl;
  logic [2*WIDTH-1:0] dbl_l;
  logic [2*WIDTH-1:0] dbl_r;

  // Rotations come from shifting a doubled copy of the operand.
  always_comb begin
    dbl   = {a, a};
    dbl_l = dbl << b;
    dbl_r = dbl >> b;
    if (rot) begin
      y = left ? dbl_l[2*WIDTH-1:WIDTH] : dbl_r[WIDTH-1:0];
    end else if (left) begin
      y = a << b;
    end else if (sign) begin
      y = $unsigned($signed(a) >>> b);
    end else begin
      y = a >> b;
    end
  end

endmodule

module shifter_arbiter #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned NREQ  = 4
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [NREQ-1:0]                  req_valid,
  output logic [NREQ-1:0]                  req_ready,
  input  logic [NREQ*WIDTH-1:0]            req_a,
  input  logic [NREQ*$clog2(WIDTH)-1:0]    req_b,
  input  logic [NREQ*3-1:0]                req_op,
  output logic                             resp_valid,
  input  logic                             resp_ready,
  output logic [WIDTH-1:0]                 resp_data,
  output logic [$clog2(NREQ)-1:0]          resp_id,
  output logic                             busy
);

  localparam int unsigned SHW = $clog2(WIDTH);
  localparam int unsigned IDW = $clog2(NREQ);

  typedef enum logic {StEmpty, StFull} state_e;

  state_e           state_q;
  logic [WIDTH-1:0] a_q;
  logic [SHW-1:0]   b_q;
  logic [2:0]       op_q;
  logic [IDW-1:0]   id_q;
  logic [IDW-1:0]   rr_ptr_q;

  logic             can_accept;
  logic             grant_found;
  logic [IDW-1:0]   grant_id;
  logic [IDW-1:0]   scan_id;
  logic             accept;
  int unsigned      scan_idx;
  int unsigned      gi;

  // Scan from rr_ptr upward, wrapping; first valid requester wins.
  always_comb begin
    can_accept  = (state_q == StEmpty) || resp_ready;
    grant_found = 1'b0;
    grant_id    = '0;
    scan_idx    = 0;
    scan_id     = '0;
    req_ready   = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      scan_idx = (32'(rr_ptr_q) + i) % NREQ;
      scan_id  = IDW'(scan_idx);
      if (!grant_found && req_valid[scan_id]) begin
        grant_found = 1'b1;
        grant_id    = scan_id;
      end
    end
    accept = can_accept && grant_found && !reset;
    if (accept) begin
      req_ready[grant_id] = 1'b1;
    end
    gi = 32'(grant_id);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StEmpty;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      id_q     <= '0;
      rr_ptr_q <= '0;
    end else if (accept) begin
      state_q  <= StFull;
      a_q      <= req_a[gi*WIDTH +: WIDTH];
      b_q      <= req_b[gi*SHW +: SHW];
      op_q     <= req_op[gi*3 +: 3];
      id_q     <= grant_id;
      rr_ptr_q <= (gi == NREQ - 1) ? '0 : grant_id + 1'b1;
    end else if (state_q == StFull && resp_ready) begin
      state_q <= StEmpty;
    end
  end

  shifter #(
    .WIDTH(WIDTH)
  ) u_shifter (
    .a    (a_q),
    .b    (b_q),
    .rot  (op_q[2]),
    .left (op_q[1]),
    .sign (op_q[0]),
    .y    (resp_data)
  );

  assign resp_valid = (state_q == StFull);
  assign busy       = resp_valid;
  assign resp_id    = id_q;

endmodule

// File: tb/tb_shifter_arbiter.sv
// Scoreboard bench for shifter_arbiter: directed cases followed by random traffic against
// a bit-level reference of the shift rules and an independent round-robin model.

module tb_shifter_arbiter;

  localparam int W   = 8;
  localparam int N   = 4;
  localparam int SHW = 3;
  localparam int IDW = 2;

  logic             clk = 1'b0;
  logic             reset;
  logic [N-1:0]     req_valid;
  logic [N-1:0]     req_ready;
  logic [N*W-1:0]   req_a;
  logic [N*SHW-1:0] req_b;
  logic [N*3-1:0]   req_op;
  logic             resp_valid;
  logic             resp_ready;
  logic [W-1:0]     resp_data;
  logic [IDW-1:0]   resp_id;
  logic             busy;

  shifter_arbiter #(
    .WIDTH(W),
    .NREQ (N)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_op     (req_op),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .resp_id    (resp_id),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int           id;
    logic [W-1:0] data;
  } exp_t;

  exp_t exp_q[$];

  bit             hv[N];
  logic [W-1:0]   ha[N];
  logic [SHW-1:0] hb[N];
  logic [2:0]     hop[N];

  int m_ptr;
  bit m_full;
  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference shift rules, one output bit at a time.
  function automatic logic [W-1:0] ref_shift(input logic [W-1:0] a, input int b,
                                             input logic [2:0] op);
    logic [W-1:0] y;
    y = '0;
    for (int i = 0; i < W; i++) begin
      if (op[2]) begin
        if (op[1]) y[(i + b) % W] = a[i];
        else       y[i] = a[(i + b) % W];
      end else if (op[1]) begin
        y[i] = (i >= b) ? a[i - b] : 1'b0;
      end else begin
        y[i] = (i + b < W) ? a[i + b] : (op[0] ? a[W-1] : 1'b0);
      end
    end
    return y;
  endfunction

  task automatic apply();
    for (int i = 0; i < N; i++) begin
      req_valid[i]            = hv[i];
      req_a[i*W +: W]         = ha[i];
      req_b[i*SHW +: SHW]     = hb[i];
      req_op[i*3 +: 3]        = hop[i];
    end
  endtask

  task automatic set_req(input int i, input logic [W-1:0] a, input logic [SHW-1:0] b,
                         input logic [2:0] op);
    hv[i]  = 1'b1;
    ha[i]  = a;
    hb[i]  = b;
    hop[i] = op;
  endtask

  task automatic clear_reqs();
    for (int i = 0; i < N; i++) hv[i] = 1'b0;
  endtask

  // One clock: drive, predict grant at negedge, update model at posedge; ends posedge+1.
  task automatic step();
    int g;
    logic [N-1:0] exp_ready;
    apply();
    @(negedge clk);
    g = -1;
    if (!reset && (!m_full || resp_ready)) begin
      for (int k = 0; k < N; k++) begin
        if (g < 0 && hv[(m_ptr + k) % N]) g = (m_ptr + k) % N;
      end
    end
    exp_ready = '0;
    if (g >= 0) exp_ready[g] = 1'b1;
    check("req_ready", 32'(req_ready), 32'(exp_ready));
    @(posedge clk);
    if (reset) begin
      exp_q.delete();
      m_full = 1'b0;
      m_ptr  = 0;
    end else if (g >= 0) begin
      exp_q.push_back('{id: g, data: ref_shift(ha[g], int'(hb[g]), hop[g])});
      hv[g]  = 1'b0;
      m_ptr  = (g + 1) % N;
      m_full = 1'b1;
    end else if (m_full && resp_ready) begin
      m_full = 1'b0;
    end
    #1;
  endtask

  // Monitor: every presented result must match the oldest expected entry.
  always @(negedge clk) begin
    if (!reset) begin
      check("resp_valid", 32'(resp_valid), 32'(m_full));
      check("busy", 32'(busy), 32'(m_full));
      if (resp_valid) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL resp_extra: got id %0d data %0h, expected no response", resp_id,
                   resp_data);
        end else begin
          check("resp_id", 32'(resp_id), 32'(exp_q[0].id));
          check("resp_data", 32'(resp_data), 32'(exp_q[0].data));
          if (resp_ready) void'(exp_q.pop_front());
        end
      end
    end
  end

  logic [W-1:0]   frz_data;
  logic [IDW-1:0] frz_id;

  initial begin
    reset      = 1'b1;
    resp_ready = 1'b1;
    m_ptr      = 0;
    m_full     = 1'b0;
    for (int i = 0; i < N; i++) set_req(i, '0, '0, '0);
    clear_reqs();
    apply();
    #1;
    step();
    step();
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_resp_data", 32'(resp_data), 32'd0);
    check("rst_resp_id", 32'(resp_id), 32'd0);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    reset = 1'b0;

    // Directed operations.
    set_req(0, 8'b10000111, 3'd3, 3'b110);
    step();
    check("t1_valid", 32'(resp_valid), 32'd1);
    check("t1_data", 32'(resp_data), 32'b00111100);
    check("t1_id", 32'(resp_id), 32'd0);
    set_req(1, 8'b10000111, 3'd1, 3'b100);
    step();
    check("t2_rotr", 32'(resp_data), 32'b11000011);
    set_req(2, 8'b10000111, 3'd2, 3'b001);
    step();
    check("t2_asr", 32'(resp_data), 32'b11100001);
    set_req(3, 8'b10000111, 3'd7, 3'b010);
    step();
    check("t2_lsl", 32'(resp_data), 32'b10000000);
    step();

    // All requesters valid from reset: strict rotation.
    reset = 1'b1;
    step();
    reset = 1'b0;
    for (int k = 0; k < 8; k++) begin
      for (int i = 0; i < N; i++) begin
        if (!hv[i]) set_req(i, W'($urandom), SHW'($urandom), 3'($urandom));
      end
      step();
      check("t3_order", 32'(resp_id), 32'(k % N));
    end
    clear_reqs();
    step();
    step();

    // Backpressure holds everything.
    set_req(0, 8'h5A, 3'd2, 3'b010);
    set_req(1, 8'hC3, 3'd5, 3'b100);
    step();
    resp_ready = 1'b0;
    frz_data   = resp_data;
    frz_id     = resp_id;
    set_req(0, 8'h11, 3'd1, 3'b001);
    for (int k = 0; k < 5; k++) begin
      step();
      check("t4_frz_data", 32'(resp_data), 32'(frz_data));
      check("t4_frz_id", 32'(resp_id), 32'(frz_id));
    end
    resp_ready = 1'b1;
    step();
    check("t4_next_id", 32'(resp_id), 32'd1);

    // Reset while full and stalled discards the pending result.
    resp_ready = 1'b0;
    reset      = 1'b1;
    step();
    reset = 1'b0;
    check("t5_valid", 32'(resp_valid), 32'd0);
    clear_reqs();
    set_req(2, 8'h81, 3'd4, 3'b000);
    resp_ready = 1'b1;
    step();
    check("t5_id", 32'(resp_id), 32'd2);
    check("t5_data", 32'(resp_data), 32'h08);

    // Random traffic.
    for (int k = 0; k < 10000; k++) begin
      for (int i = 0; i < N; i++) begin
        if (!hv[i] && ($urandom_range(0, 2) != 0))
          set_req(i, W'($urandom), SHW'($urandom), 3'($urandom));
      end
      resp_ready = ($urandom_range(0, 3) != 0);
      step();
    end

    clear_reqs();
    resp_ready = 1'b1;
    for (int k = 0; k < 4; k++) step();
    check("drain_empty", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
